lcd_power_seq: RTL and testbench
================================

LCD_POWER_SEQ -- requirements
Module: lcd_power_seq

Interface
REQ-001 SHALL have parameter T_RST_CYC, default 192000, meaning panel-reset assertion length in clk cycles (10 ms at 19.2 MHz).
REQ-002 SHALL have parameter T_WAKE_CYC, default 384000, meaning delay from reset release to timing-generator start (20 ms).
REQ-003 SHALL have parameter N_FRAMES, default 2, meaning whole frames to run with data gated before backlight on (range 1..15).
REQ-004 SHALL have parameter T_OFF_CYC, default 192000, meaning delay from backlight off to timing-generator stop.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1920000, meaning vsync watchdog limit (100 ms); used only under REQ-025.
REQ-006 SHALL have port clk, input, 1 bit, meaning pixel clock; the only clock.
REQ-007 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-008 SHALL have port enable, input, 1 bit, meaning level request for the panel to be on.
REQ-009 SHALL have port lcd_vsync, input, 1 bit, meaning vsync from the timing generator, active-high.
REQ-010 SHALL have port lcd_reset, output, 1 bit, meaning panel reset, active-low.
REQ-011 SHALL have port tg_resetn, output, 1 bit, meaning timing-generator reset, active-low.
REQ-012 SHALL have port den_gate, output, 1 bit, meaning 1 lets lcd_den and lcd_dat through.
REQ-013 SHALL have port backlight_en, output, 1 bit, meaning backlight on.
REQ-014 SHALL have port panel_on, output, 1 bit, meaning high only in state ON.
REQ-015 SHALL have port fault, output, 1 bit, meaning sticky watchdog fault.

Function
REQ-016 SHALL implement states OFF, RST, WAKE, FRAMES, ON, BL_OFF, STOP; all outputs registered and decoded from the current state.
REQ-017 SHALL drive the following per state: OFF gives lcd_reset=1, tg_resetn=0, den_gate=0, bl=0; RST sets lcd_reset=0; WAKE sets lcd_reset=1; FRAMES sets tg_resetn=1; ON sets tg_resetn=1, den_gate=1, bl=1, panel_on=1; BL_OFF sets tg_resetn=1, den_gate=1; STOP sets tg_resetn=1.
REQ-018 SHALL take these transitions: OFF to RST when enable=1; RST to WAKE after exactly T_RST_CYC cycles in RST; WAKE to FRAMES after T_WAKE_CYC cycles.
REQ-019 SHALL count rising edges of lcd_vsync in FRAMES, using a one-register edge detector, and go to ON on edge N_FRAMES+1 (first edge only aligns to a frame start).
REQ-020 SHALL go from ON to BL_OFF when enable=0, from BL_OFF to STOP after T_OFF_CYC cycles, and from STOP to OFF on the next rising edge of lcd_vsync (stop at frame boundary).
REQ-021 SHALL go directly to OFF in the next cycle, aborting power-up, when enable=0 in RST, WAKE or FRAMES.
REQ-022 SHALL ignore enable=1 in BL_OFF and STOP; the sequence completes to OFF, then re-arms if enable is still 1.
REQ-023 SHALL reload the shared down-counter on every state entry; counter width is $clog2 of the largest parameter plus 1, with no wrap.

Reset
REQ-024 SHALL on reset=1 at a clk edge enter OFF, clear the counter, the edge-detect register and fault, and give lcd_reset=1, tg_resetn=0, den_gate=0, backlight_en=0, panel_on=0, fault=0; mid-sequence reset behaves identically.

Configuration
REQ-025 SHALL, with LCD_VSYNC_TIMEOUT_EN defined, run a watchdog in FRAMES, ON and STOP: TIMEOUT_CYC cycles without a vsync rising edge sets fault=1 and forces OFF; fault clears only on reset.
REQ-026 SHALL, without LCD_VSYNC_TIMEOUT_EN, include no watchdog logic and tie fault to 0, and SHALL otherwise behave identically.

Structure
REQ-027 SHALL take the state enum and default timing constants from shared package lcd_pkg.
REQ-028 SHALL instantiate one sub-module, lcd_seq_timer (loadable down-counter with done flag), used by RST, WAKE and BL_OFF and reused by the watchdog.

Verification
REQ-029 SHALL, with T_RST_CYC=10, T_WAKE_CYC=20, N_FRAMES=2, enable=1 and vsync every 100 cycles: lcd_reset low exactly 10 cycles, then tg_resetn rises 20 cycles later, then backlight_en and panel_on rise 1 cycle after the 3rd vsync edge.
REQ-030 SHALL, from ON with T_OFF_CYC=5, on enable dropped: backlight_en falls next cycle, den_gate falls 5 cycles later, and tg_resetn falls 1 cycle after the next vsync edge.
REQ-031 SHALL, when enable drops mid-WAKE: OFF next cycle, and enable=1 again restarts at RST with a full 10-cycle reset.
REQ-032 SHALL, when enable pulses 1 during BL_OFF: no effect, reaching OFF, then RST the following cycle if enable=1.
REQ-033 SHALL, on reset asserted in ON: all outputs at reset values on the next edge.
REQ-034 SHALL, with LCD_VSYNC_TIMEOUT_EN and TIMEOUT_CYC=50, when vsync stops in ON: fault=1 and OFF exactly 50 cycles after the last edge; fault stays 1 until reset.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and default timing constants for the LCD panel power sequencer.
package lcd_pkg;

  localparam int T_RST_CYC_DEF   = 192000;
  localparam int T_WAKE_CYC_DEF  = 384000;
  localparam int N_FRAMES_DEF    = 2;
  localparam int T_OFF_CYC_DEF   = 192000;
  localparam int TIMEOUT_CYC_DEF = 1920000;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RST    = 3'd1,
    S_WAKE   = 3'd2,
    S_FRAMES = 3'd3,
    S_ON     = 3'd4,
    S_BL_OFF = 3'd5,
    S_STOP   = 3'd6
  } lcd_state_e;

  typedef struct packed {
    logic lcd_reset;
    logic tg_resetn;
    logic den_gate;
    logic backlight_en;
    logic panel_on;
  } lcd_out_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Panel-side pin levels for each sequencer state.
  function automatic lcd_out_t lcd_decode(input lcd_state_e s);
    lcd_out_t o;
    o = '{lcd_reset: 1'b1, default: 1'b0};
    case (s)
      S_RST:            o.lcd_reset = 1'b0;
      S_FRAMES, S_STOP: o.tg_resetn = 1'b1;
      S_ON: begin
        o.tg_resetn    = 1'b1;
        o.den_gate     = 1'b1;
        o.backlight_en = 1'b1;
        o.panel_on     = 1'b1;
      end
      S_BL_OFF: begin
        o.tg_resetn = 1'b1;
        o.den_gate  = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
module lcd_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_power_seq.sv
// LCD panel power-up/power-down sequencer with registered, state-decoded outputs.
// Define LCD_VSYNC_TIMEOUT_EN to add the vsync watchdog that drives fault.
module lcd_power_seq
  import lcd_pkg::*;
#(
  parameter int T_RST_CYC   = T_RST_CYC_DEF,
  parameter int T_WAKE_CYC  = T_WAKE_CYC_DEF,
  parameter int N_FRAMES    = N_FRAMES_DEF,
  parameter int T_OFF_CYC   = T_OFF_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic lcd_vsync,
  output logic lcd_reset,
  output logic tg_resetn,
  output logic den_gate,
  output logic backlight_en,
  output logic panel_on,
  output logic fault
);

  localparam int MAX_CYC = max_int(max_int(T_RST_CYC, T_WAKE_CYC),
                                   max_int(max_int(T_OFF_CYC, N_FRAMES), TIMEOUT_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  lcd_state_e       state;
  lcd_state_e       next_state;
  lcd_out_t         outs;
  logic             vsync_q;
  logic             vsync_edge;
  logic             wd_trip;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_done;
  logic [CNT_W-1:0] tmr_val;

  assign vsync_edge = lcd_vsync & ~vsync_q;

`ifdef LCD_VSYNC_TIMEOUT_EN
  logic wd_active;
  logic wd_done;
  logic fault_q;

  assign wd_active = state inside {S_FRAMES, S_ON, S_STOP};

  // Held at full count outside the watched states, restarted on every vsync edge.
  lcd_seq_timer #(.W(CNT_W)) u_wd_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (vsync_edge | ~wd_active),
    .load_val (CNT_W'(TIMEOUT_CYC - 1)),
    .dec      (1'b1),
    .done     (wd_done)
  );

  assign wd_trip = wd_active & wd_done & ~vsync_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (wd_trip) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign wd_trip = 1'b0;
  assign fault   = 1'b0;
`endif

  // NOTE: next_state takes a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_OFF:    if (enable) next_state = S_RST;
      S_RST:    if (!enable) next_state = S_OFF;
                else if (tmr_done) next_state = S_WAKE;
      S_WAKE:   if (!enable) next_state = S_OFF;
                else if (tmr_done) next_state = S_FRAMES;
      S_FRAMES: if (!enable) next_state = S_OFF;
                else if (vsync_edge && tmr_done) next_state = S_ON;
      S_ON:     if (!enable) next_state = S_BL_OFF;
      S_BL_OFF: if (tmr_done) next_state = S_STOP;
      S_STOP:   if (vsync_edge) next_state = S_OFF;
      default:  next_state = S_OFF;
    endcase
    if (wd_trip) next_state = S_OFF;
  end

  // Timed states load length-1 so they last exactly their cycle count; FRAMES counts edges.
  always_comb begin
    tmr_val = '0;
    case (next_state)
      S_RST:    tmr_val = CNT_W'(T_RST_CYC - 1);
      S_WAKE:   tmr_val = CNT_W'(T_WAKE_CYC - 1);
      S_FRAMES: tmr_val = CNT_W'(N_FRAMES);
      S_BL_OFF: tmr_val = CNT_W'(T_OFF_CYC - 1);
      default:  tmr_val = '0;
    endcase
  end

  assign tmr_load = (next_state != state);
  assign tmr_dec  = (state == S_FRAMES) ? vsync_edge : 1'b1;

  lcd_seq_timer #(.W(CNT_W)) u_seq_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  // Outputs are flopped from next_state so they always match the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_OFF;
      vsync_q <= 1'b0;
      outs    <= lcd_decode(S_OFF);
    end else begin
      state   <= next_state;
      vsync_q <= lcd_vsync;
      outs    <= lcd_decode(next_state);
    end
  end

  assign lcd_reset    = outs.lcd_reset;
  assign tg_resetn    = outs.tg_resetn;
  assign den_gate     = outs.den_gate;
  assign backlight_en = outs.backlight_en;
  assign panel_on     = outs.panel_on;

endmodule

// File: tb/tb_lcd_power_seq.sv
// Self-checking bench for lcd_power_seq: expected output timeline is built from
// event times computed arithmetically from the vsync schedule and the timing parameters.
module tb_lcd_power_seq;

  localparam int T_RST  = 10;
  localparam int T_WAKE = 20;
  localparam int N_FR   = 2;
  localparam int T_OFF  = 5;
  localparam int T_TO   = 50;

  // {lcd_reset, tg_resetn, den_gate, backlight_en, panel_on, fault}
  localparam logic [5:0] V_OFF    = 6'b100000;
  localparam logic [5:0] V_RST    = 6'b000000;
  localparam logic [5:0] V_WAKE   = 6'b100000;
  localparam logic [5:0] V_FRAMES = 6'b110000;
  localparam logic [5:0] V_ON     = 6'b111110;
  localparam logic [5:0] V_BL_OFF = 6'b111000;
  localparam logic [5:0] V_STOP   = 6'b110000;
  localparam logic [5:0] V_FAULT  = 6'b100001;

  logic clk = 1'b0;
  logic reset, enable, lcd_vsync;
  logic lcd_reset, tg_resetn, den_gate, backlight_en, panel_on, fault;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int per;
  int phase;
  bit vs_on;
  string tag;

  int         tl_t[$];
  logic [5:0] tl_v[$];

  lcd_power_seq #(
    .T_RST_CYC   (T_RST),
    .T_WAKE_CYC  (T_WAKE),
    .N_FRAMES    (N_FR),
    .T_OFF_CYC   (T_OFF),
    .TIMEOUT_CYC (T_TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .lcd_vsync    (lcd_vsync),
    .lcd_reset    (lcd_reset),
    .tg_resetn    (tg_resetn),
    .den_gate     (den_gate),
    .backlight_en (backlight_en),
    .panel_on     (panel_on),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  function automatic int pmod(input int a, input int b);
    int m;
    m = a % b;
    if (m < 0) m += b;
    return m;
  endfunction

  // vsync is high for two samples each period; its rising edge is sampled at cycles
  // congruent to phase modulo per.
  function automatic int next_edge(input int c);
    return c + 1 + pmod(phase - (c + 1), per);
  endfunction

  function automatic int last_edge(input int c);
    return c - pmod(c - phase, per);
  endfunction

  function automatic logic [5:0] exp_at(input int n);
    for (int i = tl_t.size() - 1; i >= 0; i--)
      if (tl_t[i] <= n) return tl_v[i];
    return V_OFF;
  endfunction

  task automatic push(input int t, input logic [5:0] v);
    tl_t.push_back(t);
    tl_v.push_back(v);
  endtask

  task automatic truncate(input int t);
    while (tl_t.size() > 0 && tl_t[$] > t) begin
      void'(tl_t.pop_back());
      void'(tl_v.pop_back());
    end
  endtask

  task automatic drive_vsync();
    lcd_vsync = vs_on && (pmod(cyc + 1 - phase, per) < 2);
  endtask

  task automatic new_period(input int lo, input int hi);
    per   = $urandom_range(hi, lo);
    phase = $urandom_range(per - 1, 0);
    drive_vsync();
  endtask

  task automatic step(input bit rand_en);
    logic [5:0] obs, expv;
    @(posedge clk);
    #1;
    cyc++;
    obs  = {lcd_reset, tg_resetn, den_gate, backlight_en, panel_on, fault};
    expv = exp_at(cyc);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
    if (rand_en) enable = 1'($urandom_range(1, 0));
    drive_vsync();
  endtask

  task automatic run_to(input int t, input bit rand_en);
    while (cyc < t) step(rand_en);
  endtask

  // enable goes high after cycle c: RST holds T_RST samples, WAKE T_WAKE samples,
  // then the first edge only aligns and N_FR further whole frames follow before ON.
  task automatic plan_powerup(input int c, output int on_t);
    int r, w, f;
    r    = c + 1;
    w    = r + T_RST;
    f    = w + T_WAKE;
    on_t = next_edge(f) + N_FR * per;
    push(r, V_RST);
    push(w, V_WAKE);
    push(f, V_FRAMES);
    push(on_t, V_ON);
  endtask

  task automatic plan_shutdown(input int c, output int off_t);
    int b, s;
    b     = c + 1;
    s     = b + T_OFF;
    off_t = next_edge(s);
    push(b, V_BL_OFF);
    push(s, V_STOP);
    push(off_t, V_OFF);
  endtask

  initial begin
    int on_t, off_t, d, c, lo, hi;
`ifdef LCD_VSYNC_TIMEOUT_EN
    lo = 12; hi = 45; per = 40;
`else
    lo = 12; hi = 120; per = 100;
`endif
    reset  = 1'b1;
    enable = 1'b0;
    vs_on  = 1'b1;
    phase  = $urandom_range(per - 1, 0);
    drive_vsync();
    push(0, V_OFF);

    tag = "reset";
    run_to(3, 0);
    reset = 1'b0;

    tag = "powerup";
    enable = 1'b1;
    plan_powerup(cyc, on_t);
    run_to(on_t + 10, 0);

    tag = "shutdown";
    enable = 1'b0;
    plan_shutdown(cyc, off_t);
    run_to(off_t + 5, 0);

    for (int it = 0; it < 8; it++) begin
      new_period(lo, hi);
      case (it % 4)
        0: begin
          tag = "cycle";
          enable = 1'b1;
          plan_powerup(cyc, on_t);
          run_to(on_t + $urandom_range(40, 1), 0);
          enable = 1'b0;
          plan_shutdown(cyc, off_t);
          run_to(off_t + $urandom_range(6, 1), 0);
        end
        1: begin
          tag = "abort";
          enable = 1'b1;
          plan_powerup(cyc, on_t);
          d = $urandom_range(on_t - 1, cyc + 1);
          run_to(d, 0);
          enable = 1'b0;
          truncate(d);
          push(d + 1, V_OFF);
          run_to(d + 1 + $urandom_range(4, 1), 0);
        end
        2: begin
          tag = "bl_pulse";
          enable = 1'b1;
          plan_powerup(cyc, on_t);
          run_to(on_t + $urandom_range(20, 1), 0);
          enable = 1'b0;
          plan_shutdown(cyc, off_t);
          run_to(off_t - 1, 1);
          enable = 1'b1;
          run_to(off_t, 0);
          tag = "rearm";
          plan_powerup(cyc, on_t);
          run_to(on_t + 3, 0);
          enable = 1'b0;
          plan_shutdown(cyc, off_t);
          run_to(off_t + 3, 0);
        end
        default: begin
          tag = "reset_in_on";
          enable = 1'b1;
          plan_powerup(cyc, on_t);
          run_to(on_t + $urandom_range(30, 1), 0);
          reset = 1'b1;
          c = cyc;
          truncate(c);
          push(c + 1, V_OFF);
          run_to(c + 2, 0);
          reset = 1'b0;
          tag = "after_reset";
          plan_powerup(cyc, on_t);
          run_to(on_t + 4, 0);
          enable = 1'b0;
          plan_shutdown(cyc, off_t);
          run_to(off_t + 3, 0);
        end
      endcase
    end

`ifdef LCD_VSYNC_TIMEOUT_EN
    tag = "watchdog";
    new_period(lo, hi);
    enable = 1'b1;
    plan_powerup(cyc, on_t);
    run_to(on_t + $urandom_range(30, 1), 0);
    c = cyc;
    vs_on = 1'b0;
    drive_vsync();
    d = last_edge(c) + T_TO;
    push(d, V_FAULT);
    run_to(d - 1, 0);
    enable = 1'b0;
    tag = "fault_sticky";
    run_to(d + 15, 0);
    reset = 1'b1;
    c = cyc;
    push(c + 1, V_OFF);
    run_to(c + 2, 0);
    reset = 1'b0;
    vs_on = 1'b1;
    run_to(cyc + 5, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
